// File: rtl/mmio_router.sv
// Single-outstanding MMIO front end: decodes each CPU request to SRAM or one of NDEV
// device windows, forwards it, and completes with an error if the target never answers.
module mmio_router #(
    parameter int              DW        = 32,
    parameter int              NDEV      = 4,
    parameter int              DEV_BITS  = 12,
    parameter logic [31:0]     MMIO_BASE = 32'hFFFF_0000,
    parameter int              TIMEOUT   = 255,
    parameter logic [DW-1:0]   ERR_DATA  = 32'hDEADBEEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    output logic                 ready,
    input  logic [31:0]          addr,
    input  logic [DW-1:0]        dtw,
    output logic [DW-1:0]        dtr,
    input  logic                 rw,
    output logic                 err,
    output logic                 sval,
    input  logic                 srdy,
    output logic [31:0]          saddr,
    output logic [DW-1:0]        sdtw,
    input  logic [DW-1:0]        sdtr,
    output logic                 srw,
    output logic [NDEV-1:0]      dval,
    input  logic [NDEV-1:0]      drdy,
    output logic [DEV_BITS-1:0]  daddr,
    output logic [DW-1:0]        ddtw,
    input  logic [NDEV*DW-1:0]   ddtr,
    output logic                 drw
);
    localparam int NB = $clog2(NDEV);
    localparam int HB = DEV_BITS + NB;
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t          state, state_n;
    logic [31:0]     addr_q;
    logic [DW-1:0]   dtw_q;
    logic            rw_q;
    logic            dev_q;
    logic [NB-1:0]   dev_k;
    logic [TW-1:0]   timer;

    logic            req_dev;
    logic [NB-1:0]   req_k;
    logic            sel_rdy;
    logic [DW-1:0]   sel_data;
    logic            hit;
    logic            expire;
    logic            tgt_dev_n;
    logic [NB-1:0]   tgt_k_n;
    logic [NDEV-1:0] dval_n;

    assign req_dev = (addr[31:HB] == MMIO_BASE[31:HB]);
    assign req_k   = addr[HB-1:DEV_BITS];

    assign saddr = addr_q;
    assign sdtw  = dtw_q;
    assign srw   = rw_q;
    assign daddr = addr_q[DEV_BITS-1:0];
    assign ddtw  = dtw_q;
    assign drw   = rw_q;

    always_comb begin
        sel_rdy  = dev_q ? drdy[dev_k] : srdy;
        sel_data = dev_q ? ddtr[int'(dev_k)*DW +: DW] : sdtr;
        hit      = (state == REQ) && sel_rdy;
        expire   = (state == REQ) && !sel_rdy && (TIMEOUT != 0) && (timer == TLAST);

        state_n = state;
        case (state)
            IDLE:    if (valid) state_n = REQ;
            REQ:     if (hit || expire) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Strobes are registered, so the target must be known one edge early:
        // from the live bus when accepting, from the latches while waiting.
        tgt_dev_n = (state == IDLE) ? req_dev : dev_q;
        tgt_k_n   = (state == IDLE) ? req_k : dev_k;
        dval_n    = '0;
        if (state_n == REQ && tgt_dev_n) dval_n[tgt_k_n] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ready  <= 1'b0;
            err    <= 1'b0;
            sval   <= 1'b0;
            dval   <= '0;
            dtr    <= '0;
            addr_q <= '0;
            dtw_q  <= '0;
            rw_q   <= 1'b0;
            dev_q  <= 1'b0;
            dev_k  <= '0;
            timer  <= '0;
        end else begin
            state <= state_n;
            ready <= (state_n == RESP);
            sval  <= (state_n == REQ) && !tgt_dev_n;
            dval  <= dval_n;
            case (state)
                IDLE: begin
                    if (valid) begin
                        addr_q <= addr;
                        dtw_q  <= dtw;
                        rw_q   <= rw;
                        dev_q  <= req_dev;
                        dev_k  <= req_k;
                        timer  <= '0;
                    end
                end
                REQ: begin
                    if (hit) begin
                        if (!rw_q) dtr <= sel_data;
                        err <= 1'b0;
                    end else if (expire) begin
                        if (!rw_q) dtr <= ERR_DATA;
                        err <= 1'b1;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP:    err <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
